// File: rtl/alu_exec_unit.sv
// Integer ALU execution unit: S1 reads/forwards operands and computes, S2 holds
// the result for CDB writeback under a request/grant handshake.
module alu_exec_unit #(
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_issue_valid,
  input  logic [PREG_WIDTH-1:0] i_issue_prs1,
  input  logic [PREG_WIDTH-1:0] i_issue_prs2,
  input  logic [PREG_WIDTH-1:0] i_issue_prd,
  input  logic [ROB_WIDTH-1:0]  i_issue_rob_tag,
  input  logic [31:0]           i_issue_imm,
  input  logic [3:0]            i_issue_alu_op,
  input  logic [31:0]           i_issue_pc,
  output logic                  o_ready,
  output logic [PREG_WIDTH-1:0] o_prf_raddr1,
  output logic [PREG_WIDTH-1:0] o_prf_raddr2,
  input  logic [31:0]           i_prf_rdata1,
  input  logic [31:0]           i_prf_rdata2,
  input  logic                  i_cdb_valid,
  input  logic [PREG_WIDTH-1:0] i_cdb_prd,
  input  logic [31:0]           i_cdb_data,
  output logic                  o_wb_valid,
  output logic [PREG_WIDTH-1:0] o_wb_prd,
  output logic [ROB_WIDTH-1:0]  o_wb_rob_tag,
  output logic [31:0]           o_wb_data,
  input  logic                  i_wb_grant,
  input  logic                  branch_mispredict
);

  typedef struct packed {
    logic [PREG_WIDTH-1:0] prs1;
    logic [PREG_WIDTH-1:0] prs2;
    logic [PREG_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0]  rob_tag;
    logic [31:0]           imm;
    logic [3:0]            alu_op;
    logic [31:0]           pc;
  } s1_op_t;

  s1_op_t                r_s1;
  logic                  r_s1_valid;
  logic                  r_s2_valid;
  logic [PREG_WIDTH-1:0] r_s2_prd;
  logic [ROB_WIDTH-1:0]  r_s2_rob_tag;
  logic [31:0]           r_s2_data;

  logic        w_ready;
  logic        w_issue;
  logic        w_s1_move;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_res;

  assign w_ready   = !r_s1_valid || !r_s2_valid || i_wb_grant;
  assign w_issue   = i_issue_valid && w_ready;
  assign w_s1_move = r_s1_valid && (!r_s2_valid || i_wb_grant) && !branch_mispredict;

  assign o_ready      = w_ready;
  assign o_prf_raddr1 = r_s1.prs1;
  assign o_prf_raddr2 = r_s1.prs2;

  // Re-selected every cycle, so a stalled S1 keeps tracking CDB/PRF updates.
  always_comb begin
    w_a = i_prf_rdata1;
    if (r_s1.prs1 == '0)
      w_a = '0;
    else if (i_cdb_valid && (i_cdb_prd == r_s1.prs1))
      w_a = i_cdb_data;
  end

  always_comb begin
    w_b = i_prf_rdata2;
    if (r_s1.prs2 == '0)
      w_b = '0;
    else if (i_cdb_valid && (i_cdb_prd == r_s1.prs2))
      w_b = i_cdb_data;
  end

  always_comb begin
    w_res = '0;
    case (r_s1.alu_op)
      4'd0:  w_res = w_a + w_b;
      4'd1:  w_res = w_a - w_b;
      4'd2:  w_res = w_a & w_b;
      4'd3:  w_res = w_a | w_b;
      4'd4:  w_res = w_a ^ w_b;
      4'd5:  w_res = w_a << w_b[4:0];
      4'd6:  w_res = w_a >> w_b[4:0];
      4'd7:  w_res = 32'($signed(w_a) >>> w_b[4:0]);
      4'd8:  w_res = {31'd0, ($signed(w_a) < $signed(w_b))};
      4'd9:  w_res = {31'd0, (w_a < w_b)};
      4'd10: w_res = w_a + r_s1.imm;
      4'd11: w_res = w_a & r_s1.imm;
      4'd12: w_res = w_a | r_s1.imm;
      4'd13: w_res = w_a ^ r_s1.imm;
      4'd14: w_res = r_s1.imm;
      4'd15: w_res = r_s1.pc + r_s1.imm;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (branch_mispredict) begin
      r_s1_valid <= 1'b0;
    end else if (w_issue) begin
      r_s1_valid     <= 1'b1;
      r_s1.prs1      <= i_issue_prs1;
      r_s1.prs2      <= i_issue_prs2;
      r_s1.prd       <= i_issue_prd;
      r_s1.rob_tag   <= i_issue_rob_tag;
      r_s1.imm       <= i_issue_imm;
      r_s1.alu_op    <= i_issue_alu_op;
      r_s1.pc        <= i_issue_pc;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // A grant seen during a mispredict still retires S2 on the CDB this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_prd     <= '0;
      r_s2_rob_tag <= '0;
      r_s2_data    <= '0;
    end else begin
      if (w_s1_move) begin
        r_s2_prd     <= r_s1.prd;
        r_s2_rob_tag <= r_s1.rob_tag;
        r_s2_data    <= w_res;
      end
      if (branch_mispredict)
        r_s2_valid <= 1'b0;
      else if (w_s1_move)
        r_s2_valid <= 1'b1;
      else if (i_wb_grant)
        r_s2_valid <= 1'b0;
    end
  end

  assign o_wb_valid   = r_s2_valid;
  assign o_wb_prd     = r_s2_prd;
  assign o_wb_rob_tag = r_s2_rob_tag;
  assign o_wb_data    = r_s2_data;

endmodule
